// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file: optional write->read bypass, per-register busy
// scoreboard, and a sequential clear engine so the storage array needs no reset.

module regfile_mp_sb_rdport #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                                 run,
    input  logic [ADDR_WIDTH-1:0]                raddr,
    input  logic [DATA_WIDTH-1:0]                arr_val,
    input  logic                                 busy_val,
    input  logic [NUM_WR-1:0]                    wen,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    waddr,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 rbusy
);
    always_comb begin
        rdata = arr_val;
        // ascending scan so the highest-index matching port wins
        for (int j = 0; j < NUM_WR; j++) begin
            if (BYPASS != 0 && wen[j] && waddr[j] == raddr)
                rdata = wdata[j];
        end
        if (!run || (ZERO_REG != 0 && raddr == '0))
            rdata = '0;
    end

    // busy is reported as it stood before this cycle's update
    assign rbusy = run & busy_val;
endmodule

module regfile_mp_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    output logic                           ready,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
    output logic [NUM_RD-1:0]              rbusy,
    input  logic [NUM_WR-1:0]              wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]   waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]   wdata,
    input  logic                           issue_valid,
    input  logic [ADDR_WIDTH-1:0]          issue_addr,
    output logic [2**ADDR_WIDTH-1:0]       busy_vec
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                              state_q, state_d;
    logic [ADDR_WIDTH-1:0]               clr_idx;
    logic [DATA_WIDTH-1:0]               mem [DEPTH];
    logic [DEPTH-1:0]                    busy, busy_nxt;
    logic                                run, wr_ok;
    logic [NUM_WR-1:0][ADDR_WIDTH-1:0]   wa;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wd;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   ra;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd;

    assign wa       = waddr;
    assign wd       = wdata;
    assign ra       = raddr;
    assign rdata    = rd;
    assign run      = (state_q == RUN);
    assign wr_ok    = run & ~flush;
    assign ready    = run;
    assign busy_vec = busy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (!flush && clr_idx == LAST_IDX) state_d = RUN;
            RUN:     if (flush) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            clr_idx <= '0;
        end else begin
            state_q <= state_d;
            clr_idx <= (state_q == CLEAR && !flush) ? clr_idx + 1'b1 : '0;
        end
    end

    // storage has no reset; the clear engine zeroes one entry per cycle instead
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wen[j] && !(ZERO_REG != 0 && wa[j] == '0))
                    mem[wa[j]] <= wd[j];
            end
        end
    end

    // writes retire before the issue is applied: a same-cycle new producer wins
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wen[j]) busy_nxt[wa[j]] = 1'b0;
        end
        if (issue_valid) busy_nxt[issue_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      busy <= '0;
        else if (!wr_ok) busy <= '0;
        else             busy <= busy_nxt;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_mp_sb_rdport #(
            .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_WR(NUM_WR),
            .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .run      (run),
            .raddr    (ra[k]),
            .arr_val  (mem[ra[k]]),
            .busy_val (busy[ra[k]]),
            .wen      (wen),
            .waddr    (wa),
            .wdata    (wd),
            .rdata    (rd[k]),
            .rbusy    (rbusy[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed scenarios plus a randomized run against a
// behavioural model (a 2-write/2-read bypassing file and a 1-write non-bypassing one).

module tb_regfile_mp_sb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ready;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [31:0] busy_vec;

    logic        nb_ready;
    logic [4:0]  nb_raddr;
    logic [31:0] nb_rdata;
    logic [0:0]  nb_rbusy;
    logic [0:0]  nb_wen;
    logic [4:0]  nb_waddr;
    logic [31:0] nb_wdata;
    logic [31:0] nb_busy_vec;

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl_mem [32];
    logic [31:0] mdl_busy;
    int          mdl_clr;

    always #5 clk = ~clk;

    regfile_mp_sb #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ready(ready),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .busy_vec(busy_vec)
    );

    regfile_mp_sb #(.NUM_RD(1), .NUM_WR(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .ready(nb_ready),
        .raddr(nb_raddr), .rdata(nb_rdata), .rbusy(nb_rbusy),
        .wen(nb_wen), .waddr(nb_waddr), .wdata(nb_wdata),
        .issue_valid(1'b0), .issue_addr(5'd0), .busy_vec(nb_busy_vec)
    );

    task automatic idle();
        flush = 1'b0; raddr = '0; wen = '0; waddr = '0; wdata = '0;
        issue_valid = 1'b0; issue_addr = '0;
        nb_raddr = '0; nb_wen = '0; nb_waddr = '0; nb_wdata = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            cyc();
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    // model of one clock edge, using the inputs currently driven by the bench
    task automatic mdl_edge();
        if (mdl_clr != 0) begin
            mdl_clr = flush ? 32 : mdl_clr - 1;
        end else if (flush) begin
            mdl_clr = 32;
            for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
            mdl_busy = '0;
        end else begin
            for (int j = 0; j < 2; j++)
                if (wen[j] && waddr[j*5 +: 5] != 0) mdl_mem[waddr[j*5 +: 5]] = wdata[j*32 +: 32];
            for (int j = 0; j < 2; j++)
                if (wen[j]) mdl_busy[waddr[j*5 +: 5]] = 1'b0;
            if (issue_valid) mdl_busy[issue_addr] = 1'b1;
            mdl_busy[0] = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n;
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        cyc();
        #1;
        checks++;
        if (ready !== 1'b0 || busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: ready=%b busy_vec=%h exp ready=0 busy_vec=0", ready, busy_vec);
        end
        rst_n = 1'b1;
        wait_ready(n);
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL reset_clear_len: got %0d cycles exp 32", n);
        end
        #1;
        checks++;
        if (busy_vec !== 32'h0 || rbusy !== 2'b00) begin
            failures++;
            $display("FAIL reset_busy: busy_vec=%h rbusy=%b exp 0", busy_vec, rbusy);
        end
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(31 - a), 5'(a)};
            #1;
            checks++;
            if (rdata !== 64'h0) begin
                failures++;
                $display("FAIL reset_read a=%0d: got %h exp 0", a, rdata);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        wen = 2'b01; waddr = 10'd5; wdata = {32'h0, 32'hDEADBEEF}; raddr = 10'd5;
        nb_wen = 1'b1; nb_waddr = 5'd5; nb_wdata = 32'hDEADBEEF; nb_raddr = 5'd5;
        #1;
        checks++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_same_cycle: got %h exp deadbeef", rdata[31:0]);
        end
        checks++;
        if (nb_rdata !== 32'h0) begin
            failures++;
            $display("FAIL nobypass_same_cycle: got %h exp 0", nb_rdata);
        end
        cyc();
        idle();
        raddr = 10'd5; nb_raddr = 5'd5;
        #1;
        checks++;
        if (rdata[31:0] !== 32'hDEADBEEF || nb_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bypass_next_cycle: got %h/%h exp deadbeef", rdata[31:0], nb_rdata);
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        idle();
        wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr = {5'd7, 5'd0};
        #1;
        checks++;
        if (rdata[63:32] !== 32'h22) begin
            failures++;
            $display("FAIL dual_bypass_prio: got %h exp 22", rdata[63:32]);
        end
        cyc();
        idle();
        wen = 2'b01; waddr = 10'd0; wdata = {32'h0, 32'hFFFF}; raddr = {5'd7, 5'd0};
        #1;
        checks++;
        if (rdata[63:32] !== 32'h22) begin
            failures++;
            $display("FAIL dual_write_prio: got %h exp 22", rdata[63:32]);
        end
        cyc();
        idle();
        raddr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rdata !== 64'h0) begin
            failures++;
            $display("FAIL zero_reg_write: got %h exp 0", rdata);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        issue_valid = 1'b1; issue_addr = 5'd3; raddr = 10'd3;
        #1;
        checks++;
        if (rbusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL busy_no_bypass: got %b exp 0", rbusy[0]);
        end
        cyc();
        idle();
        raddr = 10'd3;
        #1;
        checks++;
        if (rbusy[0] !== 1'b1 || busy_vec !== 32'h8) begin
            failures++;
            $display("FAIL busy_set: rbusy=%b busy_vec=%h exp 1/00000008", rbusy[0], busy_vec);
        end
        wen = 2'b01; waddr = 10'd3; issue_valid = 1'b1; issue_addr = 5'd3;
        cyc();
        idle();
        raddr = 10'd3;
        #1;
        checks++;
        if (rbusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL busy_issue_wins: got %b exp 1", rbusy[0]);
        end
        wen = 2'b01; waddr = 10'd3;
        #1;
        checks++;
        if (rbusy[0] !== 1'b1) begin
            failures++;
            $display("FAIL busy_clear_latency: got %b exp 1", rbusy[0]);
        end
        cyc();
        idle();
        raddr = 10'd3;
        issue_valid = 1'b1; issue_addr = 5'd0;
        #1;
        checks++;
        if (rbusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL busy_cleared: got %b exp 0", rbusy[0]);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL busy_zero_reg: got %h exp 0", busy_vec);
        end
    endtask

    task automatic test_flush();
        int n;
        @(negedge clk);
        idle();
        wen = 2'b01; waddr = 10'd9; wdata = {32'h0, 32'h1234};
        issue_valid = 1'b1; issue_addr = 5'd4;
        cyc();
        idle();
        raddr = 10'd9;
        #1;
        checks++;
        if (rdata[31:0] !== 32'h1234 || busy_vec !== 32'h10) begin
            failures++;
            $display("FAIL flush_pre: rdata=%h busy_vec=%h exp 1234/00000010", rdata[31:0], busy_vec);
        end
        flush = 1'b1; wen = 2'b01; waddr = 10'd9; wdata = {32'h0, 32'h5555};
        issue_valid = 1'b1; issue_addr = 5'd10;
        cyc();
        flush = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL flush_enter: ready=%b busy_vec=%h exp 0/0", ready, busy_vec);
        end
        n = 0;
        while (!ready && n < 100) begin
            wen = 2'b11; waddr = {5'd9, 5'd9}; wdata = {32'hAAAA, 32'hBBBB};
            issue_valid = 1'b1; issue_addr = 5'd9; raddr = {5'd9, 5'd9};
            #1;
            checks++;
            if (busy_vec !== 32'h0 || rdata !== 64'h0 || rbusy !== 2'b00) begin
                failures++;
                $display("FAIL flush_clear_ignore n=%0d: busy_vec=%h rdata=%h rbusy=%b exp 0", n, busy_vec, rdata, rbusy);
            end
            cyc();
            n++;
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL flush_clear_len: got %0d cycles exp 32", n);
        end
        idle();
        raddr = {5'd9, 5'd9};
        #1;
        checks++;
        if (rdata !== 64'h0 || busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL flush_after: rdata=%h busy_vec=%h exp 0/0", rdata, busy_vec);
        end
    endtask

    task automatic test_reset_midclear();
        int n;
        do_reset();
        repeat (10) cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL midclear_reset_ready: got %b exp 0", ready);
        end
        cyc();
        rst_n = 1'b1;
        wait_ready(n);
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL midclear_clear_len: got %0d cycles exp 32", n);
        end
    endtask

    task automatic test_random();
        int n;
        logic [31:0] exp_d;
        logic [4:0]  a;
        do_reset();
        wait_ready(n);
        for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
        mdl_busy = '0;
        mdl_clr = 0;
        for (int c = 0; c < 600; c++) begin
            flush = ($urandom_range(39) == 0);
            wen = 2'($urandom);
            waddr = {5'($urandom_range(7)), 5'($urandom_range(7))};
            wdata = {$urandom, $urandom};
            issue_valid = 1'($urandom);
            issue_addr = 5'($urandom_range(7));
            raddr = {5'($urandom_range(7)), 5'($urandom_range(7))};
            #1;
            checks++;
            if (ready !== (mdl_clr == 0) || busy_vec !== mdl_busy) begin
                failures++;
                $display("FAIL rand_state c=%0d: ready=%b busy_vec=%h exp %b/%h", c, ready, busy_vec, mdl_clr == 0, mdl_busy);
            end
            for (int k = 0; k < 2; k++) begin
                a = raddr[k*5 +: 5];
                exp_d = mdl_mem[a];
                for (int j = 0; j < 2; j++)
                    if (wen[j] && waddr[j*5 +: 5] == a) exp_d = wdata[j*32 +: 32];
                if (mdl_clr != 0 || a == 0) exp_d = '0;
                checks++;
                if (rdata[k*32 +: 32] !== exp_d || rbusy[k] !== (mdl_clr == 0 && mdl_busy[a])) begin
                    failures++;
                    $display("FAIL rand_read c=%0d k=%0d a=%0d: rdata=%h rbusy=%b exp %h/%b", c, k, a, rdata[k*32 +: 32], rbusy[k], exp_d, mdl_clr == 0 && mdl_busy[a]);
                end
            end
            @(posedge clk);
            mdl_edge();
            @(negedge clk);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_flush();
        test_reset_midclear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined core; replaces the single-write, two-read file.
- Configurable read and write port counts and optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard for the issue stage.
- Adds a sequential clear engine, so the array needs no per-bit reset; software or the pipeline can re-trigger the clear through `flush`.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- ZERO_REG, 1, if 1 then register 0 always reads 0, ignores writes, and is never busy.
- BYPASS, 1, if 1 then a read of an address being written this cycle returns the write data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  pulse; restarts the clear sequence.
- ready  out  1  high when the file accepts reads, writes and issues.
- raddr  in  NUM_RD*ADDR_WIDTH  read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_RD*DATA_WIDTH  read data, combinational.
- rbusy  out  NUM_RD  busy bit of each read address, combinational.
- wen  in  NUM_WR  write enables.
- waddr  in  NUM_WR*ADDR_WIDTH  write addresses.
- wdata  in  NUM_WR*DATA_WIDTH  write data.
- issue_valid  in  1  marks issue_addr as pending write.
- issue_addr  in  ADDR_WIDTH  destination register of the issued instruction.
- busy_vec  out  2**ADDR_WIDTH  full scoreboard, for debug and waveforms.

Behaviour:
- Clear FSM has two states, CLEAR and RUN, plus a counter clr_idx of width ADDR_WIDTH.
- Asynchronous reset (rst_n low): state=CLEAR, clr_idx=0, ready=0, busy_vec=0. Array contents are not reset asynchronously.
- In CLEAR:
  - Each cycle writes 0 to entry clr_idx, then increments clr_idx.
  - When clr_idx = 2**ADDR_WIDTH-1 is written, the next state is RUN.
  - The clear therefore takes exactly 2**ADDR_WIDTH cycles; ready rises on the following edge.
- While in CLEAR:
  - wen and issue_valid are ignored.
  - rdata reads 0 and rbusy reads 0.
  - busy_vec is held at 0.
- In RUN, flush=1 moves the FSM to CLEAR on the next edge: clr_idx=0, busy_vec=0, ready=0. The same-cycle write and issue are dropped.
- flush asserted during CLEAR restarts the clear from clr_idx=0.
- Reset asserted mid-clear or mid-operation aborts immediately; behaviour is then identical to power-up.
- Writes (RUN only):
  - For each port j with wen[j]=1, array[waddr_j] is updated at the edge.
  - If both ports target the same address, the highest-index port wins.
  - With ZERO_REG=1, a write to address 0 is discarded.
- Reads: rdata_k = array[raddr_k], except:
  - ZERO_REG=1 and raddr_k=0 gives 0.
  - BYPASS=1 and an enabled write port matches raddr_k this cycle gives that port's wdata; the highest-index matching port wins.
  - BYPASS=0 returns the old contents until the edge.
- Scoreboard (RUN only):
  - issue_valid sets busy[issue_addr].
  - Each enabled write clears busy[waddr_j].
  - If an issue and a write target the same address in the same cycle, busy ends set, because the new producer wins.
  - With ZERO_REG=1, busy[0] is forced to 0.
  - rbusy_k = busy[raddr_k], taken before this cycle's update. There is no bypass of busy.
- Read ports have zero latency; writes and busy updates have one-cycle latency.

Test Plan:
1. Reset release with defaults -> ready=0 for exactly 32 cycles, then ready=1; every raddr reads 0 and busy_vec=0.
2. RUN: write x5=0xDEADBEEF on port 0 while raddr0=5 in the same cycle -> with BYPASS=1, rdata0=0xDEADBEEF in that cycle. Rebuilt with BYPASS=0 -> rdata0=0 in that cycle and 0xDEADBEEF in the next.
3. NUM_WR=2: both ports write x7 in the same cycle, with 0x11 on port 0 and 0x22 on port 1 -> x7=0x22. Writing x0=0xFFFF -> x0 still reads 0.
4. Issue x3 -> rbusy=1 for raddr=3 from the next cycle. Writing x3 together with a new issue of x3 in the same cycle -> x3 stays busy. Writing x3 alone -> x3 not busy the next cycle.
5. Write x9=0x1234, then pulse flush -> ready falls, busy_vec=0, wen and issue ignored for 32 cycles; afterwards x9 reads 0.
6. Drop rst_n for 1 cycle at clr_idx=10 -> clear restarts from index 0 and takes a full 32 cycles before ready=1.
